// File: rtl/pulp_cluster_package.sv
// ----------------------------------------------------------------------------
// pulp_cluster_package
//   Shared cluster-level constants and types used by the SoC event FIFO.
//   - SOC_EVT_FIFO_DEPTH : default number of buffered SoC events
//   - SOC_EVT_WIDTH      : default width of one SoC event ID
//   - soc_evt_t          : one SoC event ID
// ----------------------------------------------------------------------------
package pulp_cluster_package;

    localparam int SOC_EVT_FIFO_DEPTH = 8;
    localparam int SOC_EVT_WIDTH      = 8;

    typedef logic [SOC_EVT_WIDTH-1:0] soc_evt_t;

endpackage

// File: rtl/cluster_soc_event_fifo_status.sv
// ----------------------------------------------------------------------------
// cluster_soc_event_fifo_status
//   Sticky overflow flag and saturating dropped-event counter for the SoC
//   event FIFO.
//   Ports:
//     clk_i, rst_ni   : clock, asynchronous active-low reset
//     drop_i          : an incoming event was dropped this cycle
//     clr_i           : clear flag and counter (a same-cycle drop wins)
//     overflow_o      : sticky overflow flag
//     overflow_cnt_o  : saturating count of dropped events
// ----------------------------------------------------------------------------
module cluster_soc_event_fifo_status #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 drop_i,
    input  logic                 clr_i,
    output logic                 overflow_o,
    output logic [CNT_WIDTH-1:0] overflow_cnt_o
);

    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        if (drop_i) begin
            overflow_d = 1'b1;
            // A drop during a clear restarts the count at this drop.
            if (clr_i) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (clr_i) begin
            overflow_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign overflow_o     = overflow_q;
    assign overflow_cnt_o = cnt_q;

endmodule

// File: rtl/cluster_soc_event_fifo.sv
// ----------------------------------------------------------------------------
// cluster_soc_event_fifo
//   Buffers SoC peripheral event IDs (no backpressure on the SoC side) and
//   presents them to the cluster event unit over a valid/ready interface.
//   When full and not popping, the newest event is dropped and counted.
//
//   Optional build macro: CLUSTER_SOC_EVT_FIFO_BYPASS_EN
//     Defined   : while empty, an incoming event falls through combinationally
//                 and is not stored if accepted in the same cycle.
//     Undefined : output comes only from storage, 1-cycle minimum latency.
//
//   Ports:
//     clk_i, rst_ni            : clock, asynchronous active-low reset
//     evt_valid_i, evt_data_i  : SoC event strobe and ID
//     flush_i                  : discard all stored entries (and any push)
//     clr_overflow_i           : clear overflow flag and counter
//     soc_periph_evt_valid_o   : event available to the event unit
//     soc_periph_evt_ready_i   : event unit accepts
//     soc_periph_evt_data_o    : event ID to the event unit
//     fill_level_o             : number of stored entries (0..DEPTH)
//     overflow_o               : sticky overflow flag
//     overflow_cnt_o           : saturating count of dropped events
// ----------------------------------------------------------------------------
module cluster_soc_event_fifo
    import pulp_cluster_package::*;
#(
    parameter int EVNT_WIDTH = SOC_EVT_WIDTH,
    parameter int DEPTH      = SOC_EVT_FIFO_DEPTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]    evt_data_i,
    input  logic                     flush_i,
    input  logic                     clr_overflow_i,
    output logic                     soc_periph_evt_valid_o,
    input  logic                     soc_periph_evt_ready_i,
    output logic [EVNT_WIDTH-1:0]    soc_periph_evt_data_o,
    output logic [$clog2(DEPTH):0]   fill_level_o,
    output logic                     overflow_o,
    output logic [CNT_WIDTH-1:0]     overflow_cnt_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [EVNT_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    logic                  empty, full;
    logic                  push, pop, drop;
    logic                  bypass_take;
    logic [EVNT_WIDTH-1:0] head_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    // Head is forced to zero while empty so the data output is clean after reset.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

`ifdef CLUSTER_SOC_EVT_FIFO_BYPASS_EN
    logic bypass_valid;

    assign bypass_valid           = empty && evt_valid_i && !flush_i;
    assign bypass_take            = bypass_valid && soc_periph_evt_ready_i;
    assign soc_periph_evt_valid_o = !empty || bypass_valid;
    assign soc_periph_evt_data_o  = bypass_valid ? evt_data_i : head_data;
`else
    assign bypass_take            = 1'b0;
    assign soc_periph_evt_valid_o = !empty;
    assign soc_periph_evt_data_o  = head_data;
`endif

    // Flush overrides both sides; a full FIFO still accepts a push when the
    // head leaves in the same cycle.
    assign pop  = !empty && soc_periph_evt_ready_i && !flush_i;
    assign push = evt_valid_i && !flush_i && !bypass_take && (!full || pop);
    assign drop = evt_valid_i && !flush_i && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; contents are only observed between pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= evt_data_i;
        end
    end

    assign fill_level_o = wr_ptr_q - rd_ptr_q;

    cluster_soc_event_fifo_status #(
        .CNT_WIDTH (CNT_WIDTH)
    ) i_status (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .drop_i         (drop),
        .clr_i          (clr_overflow_i),
        .overflow_o     (overflow_o),
        .overflow_cnt_o (overflow_cnt_o)
    );

endmodule

// File: tb/tb_cluster_soc_event_fifo.sv
module tb_cluster_soc_event_fifo;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       evt_valid_i;
    logic [7:0] evt_data_i;
    logic       flush_i;
    logic       clr_overflow_i;
    logic       soc_periph_evt_valid_o;
    logic       soc_periph_evt_ready_i;
    logic [7:0] soc_periph_evt_data_o;
    logic [3:0] fill_level_o;
    logic       overflow_o;
    logic [7:0] overflow_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    cluster_soc_event_fifo #(
        .EVNT_WIDTH (8),
        .DEPTH      (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .evt_valid_i            (evt_valid_i),
        .evt_data_i             (evt_data_i),
        .flush_i                (flush_i),
        .clr_overflow_i         (clr_overflow_i),
        .soc_periph_evt_valid_o (soc_periph_evt_valid_o),
        .soc_periph_evt_ready_i (soc_periph_evt_ready_i),
        .soc_periph_evt_data_o  (soc_periph_evt_data_o),
        .fill_level_o           (fill_level_o),
        .overflow_o             (overflow_o),
        .overflow_cnt_o         (overflow_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r,
                         input logic f, input logic c);
        evt_valid_i            = v;
        evt_data_i             = d;
        soc_periph_evt_ready_i = r;
        flush_i                = f;
        clr_overflow_i         = c;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_q [8];

        rst_ni = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        check_eq("rst_valid", soc_periph_evt_valid_o, 0);
        check_eq("rst_data",  soc_periph_evt_data_o,  0);
        check_eq("rst_level", fill_level_o,           0);
        check_eq("rst_ovf",   overflow_o,             0);
        check_eq("rst_cnt",   overflow_cnt_o,         0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Back-to-back 0x11, 0x22, 0x33 with ready high
`ifndef CLUSTER_SOC_EVT_FIFO_BYPASS_EN
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t1_lat_valid", soc_periph_evt_valid_o, 0);
        step();
        drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t1_v0", soc_periph_evt_valid_o, 1);
        check_eq("t1_d0", soc_periph_evt_data_o,  8'h11);
        check_eq("t1_l0", fill_level_o,           1);
        step();
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t1_v1", soc_periph_evt_valid_o, 1);
        check_eq("t1_d1", soc_periph_evt_data_o,  8'h22);
        check_eq("t1_l1", fill_level_o,           1);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t1_v2", soc_periph_evt_valid_o, 1);
        check_eq("t1_d2", soc_periph_evt_data_o,  8'h33);
        check_eq("t1_l2", fill_level_o,           1);
        step();
`else
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i * 8'h11), 1'b1, 1'b0, 1'b0);
            sample();
            check_eq("t1_byp_valid", soc_periph_evt_valid_o, 1);
            check_eq("t1_byp_data",  soc_periph_evt_data_o,  i * 8'h11);
            check_eq("t1_byp_level", fill_level_o,           0);
            step();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
        sample();
        check_eq("t1_end_valid", soc_periph_evt_valid_o, 0);
        check_eq("t1_end_level", fill_level_o,           0);
        step();

        // Ten events into an 8-deep FIFO with ready low: two dropped
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t2_level", fill_level_o,           8);
        check_eq("t2_ovf",   overflow_o,             1);
        check_eq("t2_cnt",   overflow_cnt_o,         2);
        check_eq("t2_head",  soc_periph_evt_data_o,  8'h01);
        step();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            sample();
            check_eq("t2_drain_valid", soc_periph_evt_valid_o, 1);
            check_eq("t2_drain_data",  soc_periph_evt_data_o,  i);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t2_empty_valid", soc_periph_evt_valid_o, 0);
        check_eq("t2_empty_level", fill_level_o,           0);
        check_eq("t2_ovf_sticky",  overflow_o,             1);
        check_eq("t2_cnt_sticky",  overflow_cnt_o,         2);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t2_clr_ovf", overflow_o,     0);
        check_eq("t2_clr_cnt", overflow_cnt_o, 0);
        step();

        // Full FIFO with simultaneous push 0x55 and pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t3_full_level", fill_level_o,          8);
        check_eq("t3_full_head",  soc_periph_evt_data_o, 8'hA1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t3_level_kept", fill_level_o,   8);
        check_eq("t3_no_ovf",     overflow_o,     0);
        check_eq("t3_no_cnt",     overflow_cnt_o, 0);
        step();
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'h55};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            sample();
            check_eq("t3_drain_data", soc_periph_evt_data_o, exp_q[i]);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t3_end_valid", soc_periph_evt_valid_o, 0);
        step();

        // 300 drops saturate the counter; clear with a drop restarts at 1
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t4_sat_cnt", overflow_cnt_o, 8'hFF);
        check_eq("t4_sat_ovf", overflow_o,     1);
        check_eq("t4_level",   fill_level_o,   8);
        step();
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t4_clrdrop_cnt", overflow_cnt_o,        1);
        check_eq("t4_clrdrop_ovf", overflow_o,            1);
        check_eq("t4_head",        soc_periph_evt_data_o, 8'hB0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t4_flush_valid", soc_periph_evt_valid_o, 0);
        check_eq("t4_flush_level", fill_level_o,           0);
        check_eq("t4_flush_cnt",   overflow_cnt_o,         1);
        step();

        // Level 5, flush together with a push of 0x77
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t5_level5", fill_level_o, 5);
        step();
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t5_valid", soc_periph_evt_valid_o, 0);
        check_eq("t5_level", fill_level_o,           0);
        check_eq("t5_ovf",   overflow_o,             1);
        check_eq("t5_cnt",   overflow_cnt_o,         1);
        step();
        sample();
        check_eq("t5_no77_valid", soc_periph_evt_valid_o, 0);
        step();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'(8'hD1 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t6_pre_level", fill_level_o,           2);
        check_eq("t6_pre_valid", soc_periph_evt_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_valid", soc_periph_evt_valid_o, 0);
        check_eq("t6_rst_level", fill_level_o,           0);
        check_eq("t6_rst_ovf",   overflow_o,             0);
        check_eq("t6_rst_cnt",   overflow_cnt_o,         0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Empty FIFO, ready high, single event 0x3C
`ifdef CLUSTER_SOC_EVT_FIFO_BYPASS_EN
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t7_byp_valid", soc_periph_evt_valid_o, 1);
        check_eq("t7_byp_data",  soc_periph_evt_data_o,  8'h3C);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t7_byp_level", fill_level_o,           0);
        check_eq("t7_byp_after", soc_periph_evt_valid_o, 0);
        step();
        drive(1'b1, 8'h3D, 1'b1, 1'b1, 1'b0);
        sample();
        check_eq("t7_byp_flush", soc_periph_evt_valid_o, 0);
        step();
`else
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t7_reg_lat", soc_periph_evt_valid_o, 0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("t7_reg_valid", soc_periph_evt_valid_o, 1);
        check_eq("t7_reg_data",  soc_periph_evt_data_o,  8'h3C);
        check_eq("t7_reg_level", fill_level_o,           1);
        step();
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("t7_end_valid", soc_periph_evt_valid_o, 0);
        check_eq("t7_end_level", fill_level_o,           0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_soc_event_fifo.md
Name: cluster_soc_event_fifo

Overview:
- Buffers SoC peripheral events (uDMA/GPIO/timer IDs) arriving from the SoC event generator.
- Delivers them to the cluster event unit through its soc_periph_evt valid/ready/data input, upstream of the cluster peripherals block.
- The SoC side has no backpressure. On overflow the newest event is dropped, counted and flagged.
- Provides fill level and overflow status for debug and for the cluster control unit.

Parameters:
- EVNT_WIDTH, 8, width of one event ID.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_WIDTH, 8, width of the saturating overflow counter.

Ports:
- clk_i  in  1  cluster clock.
- rst_ni  in  1  asynchronous active-low reset.
- evt_valid_i  in  1  SoC event strobe, one event per cycle when high.
- evt_data_i  in  EVNT_WIDTH  SoC event ID.
- flush_i  in  1  synchronous flush of all stored entries.
- clr_overflow_i  in  1  clears overflow_o and overflow_cnt_o.
- soc_periph_evt_valid_o  out  1  event available to the event unit.
- soc_periph_evt_ready_i  in  1  event unit accepts.
- soc_periph_evt_data_o  out  EVNT_WIDTH  event ID to the event unit.
- fill_level_o  out  $clog2(DEPTH)+1  number of stored entries.
- overflow_o  out  1  sticky overflow flag.
- overflow_cnt_o  out  CNT_WIDTH  saturating count of dropped events.

Behaviour:
- Reset values: all outputs 0; read/write pointers 0; storage contents don't-care.
- Internal state: circular buffer, wr_ptr and rd_ptr each $clog2(DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- Push: evt_valid_i && !full writes at wr_ptr[idx]; wr_ptr increments.
- Pop: soc_periph_evt_valid_o && soc_periph_evt_ready_i; rd_ptr increments.
- Output signals:
  - soc_periph_evt_valid_o = !empty.
  - soc_periph_evt_data_o = mem[rd_ptr[idx]], registered storage read.
  - Default latency from push to valid is 1 cycle.
- Handshake: once valid is high, data stays stable until accepted; valid never drops without a pop or a flush.
- Full and push in the same cycle:
  - With a pop in that cycle: the push is accepted, the level is unchanged and no overflow is recorded.
  - Without a pop: the event is dropped, overflow_o is set, and overflow_cnt_o increments, saturating at all-ones.
- Empty and pop: impossible, because valid is low.
- Simultaneous push and pop at level 1: both take effect, the new entry becomes the head next cycle, and valid stays high.
- fill_level_o = wr_ptr - rd_ptr, modulo 2^(idx+1); its range is 0..DEPTH.
- Pointer wrap-around is natural binary wrap; no special case.
- flush_i has priority over pop and push in the same cycle:
  - rd_ptr := wr_ptr and the FIFO becomes empty.
  - A push in the flush cycle is discarded and is not counted as overflow.
  - The overflow status is untouched.
- clr_overflow_i:
  - Clears overflow_o and overflow_cnt_o next cycle.
  - If a drop happens in the same cycle, the counter becomes 1 and the flag becomes 1 (set wins over clear).
- Reset mid-operation: asynchronous clear of pointers and status; queued events are lost. valid falls immediately on reset assertion.

Optional Feature:
- Macro: CLUSTER_SOC_EVT_FIFO_BYPASS_EN.
- When defined, zero-latency fall-through applies while the FIFO is empty:
  - evt_valid_i drives soc_periph_evt_valid_o combinationally, and evt_data_i drives soc_periph_evt_data_o.
  - If soc_periph_evt_ready_i is high that cycle, the event is consumed and not written.
  - Otherwise the event is written normally.
  - flush_i suppresses bypass valid.
- When undefined: purely registered output, 1-cycle minimum latency, no combinational path from evt_* to soc_periph_evt_*.

Decomposition:
- pulp_cluster_package:
  - SOC_EVT_FIFO_DEPTH constant (default 8).
  - typedef soc_evt_t as logic [EVNT_WIDTH-1:0].
- One sub-module, cluster_soc_event_fifo_status, holds the overflow flag and saturating counter logic.
- Storage and pointers stay in the top module.

Test Plan:
- Reset, then push IDs 0x11, 0x22, 0x33 back-to-back with ready=1 → valid from cycle+1, data 0x11, 0x22, 0x33 in order; fill_level_o peaks at 1.
- ready=0, push 10 events 0x01..0x0A with DEPTH=8 → fill_level_o=8; overflow_o=1 and overflow_cnt_o=2 (0x09 and 0x0A dropped); then ready=1 drains 0x01..0x08.
- Full FIFO with simultaneous push 0x55 and pop → no overflow; level stays 8; 0x55 is the last entry drained.
- Overflow 300 events with CNT_WIDTH=8 → overflow_cnt_o saturates at 0xFF; clr_overflow_i together with one more drop → cnt=1, flag=1.
- Level 5, assert flush_i together with a push of 0x77 → next cycle valid=0, level 0; 0x77 is never delivered; overflow state unchanged.
- With CLUSTER_SOC_EVT_FIFO_BYPASS_EN, FIFO empty, ready=1, push 0x3C → valid and data 0x3C in the same cycle; level stays 0. Without the macro → valid appears the next cycle.
